// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

   typedef enum logic [2:0] {
      S_RESET,
      S_FETCH,
      S_WAIT,
      S_HOLD,
      S_DROP
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with load, hold, flush and bubble controls
module ifid_reg
   import fetch_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            load,
   input  logic            write,
   input  logic [XLEN-1:0] load_pc,
   input  logic [31:0]     load_instr,
   output logic [XLEN-1:0] ifid_pc,
   output logic [31:0]     ifid_instr,
   output logic            ifid_valid
);

   // Flush and bubble only kill the valid bit; pc/instr keep their last contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid_pc    <= '0;
         ifid_instr <= NOP_INSTR;
         ifid_valid <= 1'b0;
      end else if (flush) begin
         ifid_valid <= 1'b0;
      end else if (load) begin
         ifid_pc    <= load_pc;
         ifid_instr <= load_instr;
         ifid_valid <= 1'b1;
      end else if (write) begin
         ifid_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV64 instruction fetch stage: PC, single-outstanding imem FSM, hold buffer
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pcwrite,
   input  logic            ifid_write,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic [XLEN-1:0] ifid_pc,
   output logic [31:0]     ifid_instr,
   output logic            ifid_valid
);

   fetch_state_t    state, next_state;
   logic [XLEN-1:0] pc, pc_next, pc_plus4, redirect_target;

   logic            hold_valid;
   logic [XLEN-1:0] hold_pc;
   logic [31:0]     hold_instr;
   logic            hold_capture, hold_release;

   logic            advance;
   logic            ifid_load, ifid_flush;
   logic [XLEN-1:0] load_pc;
   logic [31:0]     load_instr;

   assign advance         = pcwrite & ifid_write & ~redirect_valid;
   assign pc_plus4        = pc + XLEN'(4);
   assign redirect_target = redirect_pc & ~XLEN'(3);

   always_comb begin
      next_state   = state;
      pc_next      = pc;
      imem_req     = 1'b0;
      imem_addr    = pc;
      ifid_load    = 1'b0;
      ifid_flush   = 1'b0;
      load_pc      = pc;
      load_instr   = imem_rdata;
      hold_capture = 1'b0;
      hold_release = 1'b0;

      if (redirect_valid) begin
         // No request goes out this cycle, so only a response still owed can be outstanding.
         ifid_flush = 1'b1;
         pc_next    = redirect_target;
         if ((state == S_WAIT || state == S_DROP) && !imem_rvalid)
            next_state = S_DROP;
         else
            next_state = S_FETCH;
      end else begin
         unique case (state)
            S_RESET: begin
               next_state = S_FETCH;
            end
            S_FETCH: begin
               imem_req  = 1'b1;
               imem_addr = pc;
               if (imem_ready)
                  next_state = S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (advance) begin
                     ifid_load  = 1'b1;
                     pc_next    = pc_plus4;
                     imem_req   = 1'b1;
                     imem_addr  = pc_plus4;
                     next_state = imem_ready ? S_WAIT : S_FETCH;
                  end else begin
                     hold_capture = 1'b1;
                     next_state   = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (advance) begin
                  ifid_load    = hold_valid;
                  load_pc      = hold_pc;
                  load_instr   = hold_instr;
                  hold_release = 1'b1;
                  pc_next      = pc_plus4;
                  next_state   = S_FETCH;
               end
            end
            S_DROP: begin
               if (imem_rvalid)
                  next_state = S_FETCH;
            end
            default: begin
               next_state = S_RESET;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_RESET;
         pc    <= RESET_PC;
      end else begin
         state <= next_state;
         pc    <= pc_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid <= 1'b0;
         hold_pc    <= '0;
         hold_instr <= NOP_INSTR;
      end else if (redirect_valid) begin
         hold_valid <= 1'b0;
      end else if (hold_capture) begin
         hold_valid <= 1'b1;
         hold_pc    <= pc;
         hold_instr <= imem_rdata;
      end else if (hold_release) begin
         hold_valid <= 1'b0;
      end
   end

   ifid_reg #(
      .XLEN (XLEN)
   ) u_ifid_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (ifid_flush),
      .load       (ifid_load),
      .write      (ifid_write),
      .load_pc    (load_pc),
      .load_instr (load_instr),
      .ifid_pc    (ifid_pc),
      .ifid_instr (ifid_instr),
      .ifid_valid (ifid_valid)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with memory model and IF/ID scoreboard
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            pcwrite = 1'b1;
   logic            ifid_write = 1'b1;
   logic            redirect_valid = 1'b0;
   logic [XLEN-1:0] redirect_pc = '0;
   logic            imem_ready = 1'b1;
   logic            imem_rvalid = 1'b0;
   logic [31:0]     imem_rdata = '0;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] ifid_pc;
   logic [31:0]     ifid_instr;
   logic            ifid_valid;

   always #5 clk = ~clk;

   fetch_unit #(
      .XLEN     (XLEN),
      .RESET_PC (64'h0)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pcwrite        (pcwrite),
      .ifid_write     (ifid_write),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .ifid_pc        (ifid_pc),
      .ifid_instr     (ifid_instr),
      .ifid_valid     (ifid_valid)
   );

   typedef struct {
      logic [63:0] addr;
      int          epoch;
      int          due;
   } req_t;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } ent_t;

   typedef struct {
      logic        exp_req;
      logic [63:0] exp_addr;
      logic        exp_valid;
      logic [63:0] exp_ipc;
   } row_t;

   req_t        mem_q[$];
   ent_t        sb_q[$];
   row_t        tbl[6];

   int          checks = 0;
   int          errors = 0;
   int          cycle = 0;
   int          epoch = 0;
   int          resp_lat = 0;
   int          n_acc = 0;
   logic [63:0] exp_req_addr = '0;
   logic        exp_v = 1'b0;
   logic [63:0] exp_ipc = '0;
   logic [31:0] exp_instr = NOP_INSTR;
   logic        s_req, s_valid;
   logic [63:0] s_addr, s_ipc;
   logic [63:0] last_acc_addr = '0;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return {a[31:2], 2'b11} ^ 32'h5A00_0000;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out at cycle %0d", name, cycle);
   endtask

   // One clock: drive memory response, sample at negedge, update model after the edge.
   task automatic tick();
      logic acc, resp, live;
      req_t r;
      ent_t e;
      resp = (mem_q.size() > 0) && (mem_q[0].due <= cycle);
      imem_rvalid = resp;
      imem_rdata  = resp ? mem_word(mem_q[0].addr) : 32'h0;
      @(negedge clk);
      s_req   = imem_req;
      s_addr  = imem_addr;
      s_valid = ifid_valid;
      s_ipc   = ifid_pc;
      acc     = imem_req && imem_ready;
      if (redirect_valid)
         check("no_req_on_redirect", imem_req, 1'b0);
      @(posedge clk);
      #1;
      live = 1'b0;
      if (resp) begin
         r    = mem_q.pop_front();
         live = (r.epoch == epoch) && !redirect_valid;
      end
      if (acc) begin
         check("req_addr", s_addr, exp_req_addr);
         exp_req_addr = exp_req_addr + 64'd4;
         mem_q.push_back('{s_addr, epoch, cycle + 1 + resp_lat});
         check("single_outstanding", mem_q.size(), 1);
         last_acc_addr = s_addr;
         n_acc++;
      end
      if (redirect_valid) begin
         exp_req_addr = redirect_pc & ~64'h3;
         epoch++;
         sb_q.delete();
         exp_v = 1'b0;
      end else begin
         if (live)
            sb_q.push_back('{r.addr, mem_word(r.addr)});
         if (pcwrite && ifid_write) begin
            if (sb_q.size() > 0) begin
               e         = sb_q.pop_front();
               exp_v     = 1'b1;
               exp_ipc   = e.pc;
               exp_instr = e.instr;
            end else begin
               exp_v = 1'b0;
            end
         end else if (ifid_write) begin
            exp_v = 1'b0;
         end
      end
      check("ifid_valid", ifid_valid, exp_v);
      check("ifid_pc", ifid_pc, exp_ipc);
      check("ifid_instr", ifid_instr, exp_instr);
      cycle++;
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_imem_req", imem_req, 1'b0);
      check("rst_ifid_valid", ifid_valid, 1'b0);
      check("rst_ifid_pc", ifid_pc, 64'h0);
      check("rst_ifid_instr", ifid_instr, NOP_INSTR);
      imem_rvalid    = 1'b0;
      redirect_valid = 1'b0;
      pcwrite        = 1'b1;
      ifid_write     = 1'b1;
      imem_ready     = 1'b1;
      resp_lat       = 0;
      // Any response still owed arrives right after release, stale.
      foreach (mem_q[i]) mem_q[i].due = cycle;
      epoch++;
      sb_q.delete();
      exp_v        = 1'b0;
      exp_ipc      = '0;
      exp_instr    = NOP_INSTR;
      exp_req_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic run_table();
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("tbl%0d_req", i), s_req, tbl[i].exp_req);
         if (tbl[i].exp_req)
            check($sformatf("tbl%0d_addr", i), s_addr, tbl[i].exp_addr);
         check($sformatf("tbl%0d_valid", i), s_valid, tbl[i].exp_valid);
         if (tbl[i].exp_valid)
            check($sformatf("tbl%0d_ifid_pc", i), s_ipc, tbl[i].exp_ipc);
      end
   endtask

   task automatic wait_acc(input int target, input string name);
      int k;
      for (k = 0; k < 20 && n_acc < target; k++) tick();
      if (n_acc < target) timeout(name);
   endtask

   initial begin
      logic [63:0] p0;
      int          n0;
      bit          found;

      // Cycles after reset release, zero-wait memory, no stalls.
      tbl[0] = '{1'b0, 64'h0,  1'b0, 64'h0};
      tbl[1] = '{1'b1, 64'h0,  1'b0, 64'h0};
      tbl[2] = '{1'b1, 64'h4,  1'b0, 64'h0};
      tbl[3] = '{1'b1, 64'h8,  1'b1, 64'h0};
      tbl[4] = '{1'b1, 64'hC,  1'b1, 64'h4};
      tbl[5] = '{1'b1, 64'h10, 1'b1, 64'h8};

      do_reset();
      run_table();
      repeat (3) tick();

      // Two-cycle stall while a response lands: goes to hold buffer, then appears.
      p0 = exp_ipc;
      pcwrite = 1'b0;
      ifid_write = 1'b0;
      tick();
      check("stall1_pc", ifid_pc, p0);
      tick();
      check("stall2_pc", ifid_pc, p0);
      pcwrite = 1'b1;
      ifid_write = 1'b1;
      tick();
      check("after_stall_pc", ifid_pc, p0 + 64'd4);
      check("after_stall_valid", ifid_valid, 1'b1);
      repeat (4) tick();

      // Redirect while a request is outstanding without a response this cycle.
      resp_lat = 1;
      repeat (4) tick();
      found = 0;
      for (int k = 0; k < 10; k++) begin
         if (mem_q.size() > 0 && mem_q[0].due > cycle) begin
            found = 1;
            break;
         end
         tick();
      end
      if (!found) timeout("find_outstanding");
      redirect_valid = 1'b1;
      redirect_pc = 64'h1002;
      tick();
      redirect_valid = 1'b0;
      check("redir_flush_valid", ifid_valid, 1'b0);
      n0 = n_acc;
      wait_acc(n0 + 1, "redir_drop_req");
      check("redir_drop_addr", last_acc_addr, 64'h1000);
      repeat (6) tick();

      // Redirect coinciding with a response: no drop, target requested next cycle.
      resp_lat = 0;
      repeat (3) tick();
      found = 0;
      for (int k = 0; k < 10; k++) begin
         if (mem_q.size() > 0 && mem_q[0].due <= cycle) begin
            found = 1;
            break;
         end
         tick();
      end
      if (!found) timeout("find_rvalid");
      redirect_valid = 1'b1;
      redirect_pc = 64'h2000;
      tick();
      redirect_valid = 1'b0;
      imem_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) imem_ready = 1'b1;
         tick();
         check($sformatf("fetch_stall%0d_req", k), s_req, 1'b1);
         check($sformatf("fetch_stall%0d_addr", k), s_addr, 64'h2000);
      end
      repeat (4) tick();

      // PC wraps from the top of the address space.
      redirect_valid = 1'b1;
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      n0 = n_acc;
      wait_acc(n0 + 1, "wrap_first");
      check("wrap_addr_top", last_acc_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      wait_acc(n0 + 2, "wrap_second");
      check("wrap_addr_zero", last_acc_addr, 64'h0);
      repeat (4) tick();

      // Reset mid-transaction; the stale response lands after release and is ignored.
      resp_lat = 2;
      repeat (3) tick();
      do_reset();
      run_table();
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
